div_ctrl: RTL and testbench

Multi-cycle sequencer for MIPS32 DIV/DIVU that produces the 64-bit {HI,LO} value later written back by the HI/LO write path. Sits beside the EX stage: accepts operands, stalls the pipeline while iterating, and pulses ready with the result. Radix-2 restoring division, one quotient bit per cycle, with support for signed operands, divide-by-zero and flush.

---
 rtl/mips32_div_pkg.sv | 26 ++
 rtl/div_sign_fix.sv | 23 ++
 rtl/div_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips32_div_pkg.sv
// Shared definitions for the MIPS32 DIV/DIVU sequencer.
//
// Contents:
//   div_state_e    : sequencer state encoding (IDLE / DIVZERO / ON / END)
//   DIV_DATA_W     : default operand width
//   div_cnt_w()    : iteration-counter width for a given operand width
//   DIVZERO_LO_ALL : all-ones pattern, sliced to DATA_W bits and returned
//                    as LO on divide-by-zero
package mips32_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } div_state_e;

    localparam int DIV_DATA_W = 32;

    localparam logic [63:0] DIVZERO_LO_ALL = '1;

    function automatic int div_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational two's-complement negate helper for the divider.
// Used at entry to take absolute values of the operands and at exit to
// restore the signs of quotient and remainder.
//
// Ports:
//   a, b         : input values
//   neg_a, neg_b : 1 = negate the corresponding value
//   a_out, b_out : conditionally negated values
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         neg_a,
    input  logic         neg_b,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out
);

    assign a_out = neg_a ? (W'(0) - a) : a;
    assign b_out = neg_b ? (W'(0) - b) : b;

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for MIPS32 DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write path, stalls the
// pipeline while iterating and pulses div_ready_o for one cycle with the
// result.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   div_start_i    : EX holds a divide (held until ready)
//   div_signed_i   : 1 = DIV, 0 = DIVU
//   div_opa_i      : dividend (rs)
//   div_opb_i      : divisor (rt)
//   flush_i        : annul the in-flight divide
//   div_ready_o    : one-cycle result-valid pulse
//   div_res_o      : {remainder (HI), quotient (LO)}, registered
//   stall_o        : pipeline stall request
//   div_busy_cnt_o : (only with DIV_BUSY_CNT_EN) saturating count of
//                    cycles spent in ON or DIVZERO
//
// Optional build macro: DIV_BUSY_CNT_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for div_start_i; latches operands on start
// DIVZERO | divisor was zero; forms {dividend, all-ones} result
// ON      | one quotient bit per cycle, DATA_W cycles
// END     | div_ready_o high, div_res_o valid; always returns to IDLE
module div_ctrl
    import mips32_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                div_start_i,
    input  logic                div_signed_i,
    input  logic [DATA_W-1:0]   div_opa_i,
    input  logic [DATA_W-1:0]   div_opb_i,
    input  logic                flush_i,
    output logic                div_ready_o,
    output logic [2*DATA_W-1:0] div_res_o,
    output logic                stall_o
`ifdef DIV_BUSY_CNT_EN
    ,
    output logic [31:0]         div_busy_cnt_o
`endif
);

    localparam int CNT_W = div_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] DIVZERO_LO = DIVZERO_LO_ALL[DATA_W-1:0];

    div_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W-1:0]   opa_raw;
    logic                sign_q;
    logic                sign_r;

    // Entry sign handling: magnitudes only for signed divides.
    logic                neg_a_in;
    logic                neg_b_in;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;

    assign neg_a_in = div_signed_i & div_opa_i[DATA_W-1];
    assign neg_b_in = div_signed_i & div_opb_i[DATA_W-1];

    div_sign_fix #(.W(DATA_W)) u_fix_in (
        .a     (div_opa_i),
        .b     (div_opb_i),
        .neg_a (neg_a_in),
        .neg_b (neg_b_in),
        .a_out (abs_a),
        .b_out (abs_b)
    );

    // One restoring step. The partial remainder is DATA_W+1 bits wide
    // because the shifted remainder can exceed 2^DATA_W-1 before the
    // subtract; after a successful subtract it is always below the
    // divisor, so the low DATA_W bits of the difference are exact.
    logic [DATA_W:0]     partial;
    logic                fits;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quo_next;

    assign partial  = {rem, quo[DATA_W-1]};
    assign fits     = (partial >= {1'b0, dvs});
    assign rem_next = fits ? (partial[DATA_W-1:0] - dvs) : partial[DATA_W-1:0];
    assign quo_next = {quo[DATA_W-2:0], fits};

    // Exit sign handling on the final step's values, so the signed result
    // is registered in the same edge that enters END.
    logic [DATA_W-1:0]   fix_rem;
    logic [DATA_W-1:0]   fix_quo;

    div_sign_fix #(.W(DATA_W)) u_fix_out (
        .a     (rem_next),
        .b     (quo_next),
        .neg_a (sign_r),
        .neg_b (sign_q),
        .a_out (fix_rem),
        .b_out (fix_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            opa_raw     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            div_ready_o <= 1'b0;
            div_res_o   <= '0;
        end else if (flush_i) begin
            // Flush wins over everything; result register is left alone.
            state       <= ST_IDLE;
            cnt         <= '0;
            div_ready_o <= 1'b0;
        end else begin
            div_ready_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (div_start_i) begin
                        rem     <= '0;
                        quo     <= abs_a;
                        dvs     <= abs_b;
                        opa_raw <= div_opa_i;
                        sign_q  <= neg_a_in ^ neg_b_in;
                        sign_r  <= neg_a_in;
                        cnt     <= '0;
                        state   <= (div_opb_i == '0) ? ST_DIVZERO : ST_ON;
                    end
                end
                ST_DIVZERO: begin
                    div_res_o   <= {opa_raw, DIVZERO_LO};
                    div_ready_o <= 1'b1;
                    state       <= ST_END;
                end
                ST_ON: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        div_res_o   <= {fix_rem, fix_quo};
                        div_ready_o <= 1'b1;
                        state       <= ST_END;
                    end
                end
                ST_END: begin
                    // Start is still high here but belongs to the
                    // instruction that is completing now.
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Forced low while reset is asserted even if EX still holds start.
    assign stall_o = div_start_i & ~div_ready_o & rst_n;

`ifdef DIV_BUSY_CNT_EN
    logic [31:0] busy_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (((state == ST_ON) || (state == ST_DIVZERO)) && (busy_cnt != 32'hFFFF_FFFF)) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end

    assign div_busy_cnt_o = busy_cnt;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected results with the
// cycle they must appear in; a monitor pops on every div_ready_o pulse.
module tb_div_ctrl;

    logic        clk;
    logic        rst_n;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] div_opa_i;
    logic [31:0] div_opb_i;
    logic        flush_i;
    logic        div_ready_o;
    logic [63:0] div_res_o;
    logic        stall_o;
`ifdef DIV_BUSY_CNT_EN
    logic [31:0] div_busy_cnt_o;
`endif

    div_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_start_i  (div_start_i),
        .div_signed_i (div_signed_i),
        .div_opa_i    (div_opa_i),
        .div_opb_i    (div_opb_i),
        .flush_i      (flush_i),
        .div_ready_o  (div_ready_o),
        .div_res_o    (div_res_o),
        .stall_o      (stall_o)
`ifdef DIV_BUSY_CNT_EN
        ,
        .div_busy_cnt_o (div_busy_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && div_ready_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_res"}, div_res_o, e.res);
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one divide starting in the current cycle (C0) and follow it to
    // END, checking stall_o each cycle. Called just after a rising edge.
    task automatic run_div(input string nm, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int lat, input logic keep);
        exp_t e;
        int   c0;
        div_start_i  = 1'b1;
        div_signed_i = sgn;
        div_opa_i    = a;
        div_opb_i    = b;
        c0 = cyc;
        e.res  = exp_res;
        e.cyc  = c0 + lat;
        e.name = nm;
        exp_q.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k == 0 || k == lat - 1 || k == lat)
                chk({nm, "_stall"}, 64'(stall_o), (k == lat) ? 64'd0 : 64'd1);
        end
        @(posedge clk);
        #1;
        if (!keep) div_start_i = 1'b0;
    endtask

    logic [63:0] prior_res;
    int          saw_ready;

    initial begin
        rst_n        = 1'b0;
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        div_opa_i    = 32'd0;
        div_opb_i    = 32'd0;
        flush_i      = 1'b0;
        #2;
        chk("rst_ready", 64'(div_ready_o), 64'd0);
        chk("rst_res", div_res_o, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        div_start_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_res", div_res_o, 64'd0);

        run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 1'b0);
        run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 1'b0);
        run_div("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          33, 1'b0);
        run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          33, 1'b0);
        run_div("div_m8_m3",    1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE, 32'd2},          33, 1'b0);
        run_div("divu_big_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},          33, 1'b0);
        run_div("divu_big_sgn", 1'b0, 32'hFFFF_FFF9,  32'd2,          {32'd1, 32'h7FFF_FFFC},          33, 1'b0);
        run_div("divu_0_5",     1'b0, 32'd0,          32'd5,          {32'd0, 32'd0},                  33, 1'b0);
        run_div("divu_5_0",     1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF},           2, 1'b0);
        run_div("div_min_0",    1'b1, 32'h8000_0000,  32'd0,          {32'h8000_0000, 32'hFFFF_FFFF},   2, 1'b0);
        prior_res = {32'h8000_0000, 32'hFFFF_FFFF};

        // Flush in C10 of DIVU 100/7: no ready, result register untouched.
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        div_opa_i    = 32'd100;
        div_opb_i    = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        div_start_i = 1'b0;
        @(negedge clk);
        chk("flush_stall", 64'(stall_o), 64'd0);
        saw_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_ready_o) saw_ready++;
        end
        chk("flush_no_ready", 64'(saw_ready), 64'd0);
        chk("flush_res_hold", div_res_o, prior_res);
        @(posedge clk);
        #1;
        run_div("after_flush", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);

        // Back-to-back with start held continuously: pulses 34 cycles apart.
        run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b1);
        run_div("b2b_8_3", 1'b0, 32'd8, 32'd3, {32'd2, 32'd2}, 33, 1'b0);

        // Asynchronous reset in C15 of a divide.
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        div_opa_i    = 32'd100;
        div_opb_i    = 32'd7;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(div_ready_o), 64'd0);
        chk("midrst_res", div_res_o, 64'd0);
        chk("midrst_stall", 64'(stall_o), 64'd0);
`ifdef DIV_BUSY_CNT_EN
        chk("midrst_busy", 64'(div_busy_cnt_o), 64'd0);
`endif
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        saw_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_ready_o) saw_ready++;
        end
        chk("postrst_no_ready", 64'(saw_ready), 64'd0);
        @(posedge clk);
        #1;
        run_div("postrst_div", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
`ifdef DIV_BUSY_CNT_EN
        chk("busy_cnt_32", 64'(div_busy_cnt_o), 64'd32);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
